// File: rtl/router_pkt_tx_if.sv
// Command, payload and packet-side signals of the router packet transmitter.
// The master modport is the driving side; the slave modport is the transmitter.
interface router_pkt_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dest;
  logic [3:0] cmd_len;
  logic       err_inject;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       tx_active;
  logic       cmd_err;

  modport master (
    output cmd_valid, cmd_dest, cmd_len, err_inject, pl_valid, pl_data, busy,
    input  cmd_ready, pl_ready, pkt_valid, pkt_data, tx_active, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_dest, cmd_len, err_inject, pl_valid, pl_data, busy,
    output cmd_ready, pl_ready, pkt_valid, pkt_data, tx_active, cmd_err
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a whole payload, then emits header, data and
// parity as one unbroken pkt_valid burst followed by a forced idle gap.
//
// state  | meaning
// IDLE   | ready for a command
// FILL   | accepting payload bytes into the buffer
// WAIT   | payload complete, holding off while the router is busy
// HDR    | header byte on the wire
// DATA   | payload bytes on the wire
// PAR    | parity byte on the wire
// GAP    | forced idle cycles before the next command
module router_pkt_tx #(
  parameter int MAX_LEN    = 15,
  parameter int GAP_CYCLES = 2
) (
  input logic            clk,
  input logic            resetn,
  router_pkt_tx_if.slave bus
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_WAIT, S_HDR, S_DATA, S_PAR, S_GAP
  } state_t;

  state_t          state, state_d;
  logic [1:0]      dest_q;
  logic [3:0]      len_q;
  logic [3:0]      fill_cnt;
  logic [3:0]      rd_idx, rd_idx_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic [7:0]      parity;
  logic [7:0]      mem [MAX_LEN];
  logic            pkt_valid_q, pkt_valid_d;
  logic [7:0]      pkt_data_q, pkt_data_d;
  logic            cmd_err_q;
  logic            cmd_ok, cmd_fire, pl_ready_c, pl_fire;
  logic [7:0]      header;

  assign cmd_ok     = (bus.cmd_dest != 2'd3) && (bus.cmd_len != 4'd0) &&
                      (int'(bus.cmd_len) <= MAX_LEN);
  assign cmd_fire   = bus.cmd_valid && (state == S_IDLE);
  assign pl_ready_c = (state == S_FILL) && (fill_cnt < len_q);
  assign pl_fire    = bus.pl_valid && pl_ready_c;
  assign header     = {2'b00, len_q, dest_q};

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.pl_ready  = pl_ready_c;
  assign bus.tx_active = (state != S_IDLE);
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.pkt_data  = pkt_data_q;
  assign bus.cmd_err   = cmd_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d     = state;
    rd_idx_d    = rd_idx;
    gap_d       = gap_cnt;
    pkt_data_d  = 8'h00;
    case (state)
      S_IDLE: if (cmd_fire && cmd_ok) state_d = S_FILL;
      S_FILL: if (fill_cnt == len_q) state_d = S_WAIT;
      S_WAIT: if (!bus.busy) state_d = S_HDR;
      S_HDR: begin
        state_d  = S_DATA;
        rd_idx_d = 4'd0;
      end
      S_DATA: begin
        if (rd_idx == len_q - 4'd1) state_d = S_PAR;
        else                        rd_idx_d = rd_idx + 4'd1;
      end
      S_PAR: begin
        state_d = S_GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (gap_cnt == '0) state_d = S_IDLE;
        else               gap_d = gap_cnt - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered against the next state so the header lands on the
    // same edge that enters HDR.
    pkt_valid_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_PAR);
    case (state_d)
      S_HDR:   pkt_data_d = header;
      S_DATA:  pkt_data_d = mem[rd_idx_d];
      S_PAR:   pkt_data_d = parity;
      default: pkt_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dest_q      <= 2'd0;
      len_q       <= 4'd0;
      fill_cnt    <= 4'd0;
      rd_idx      <= 4'd0;
      gap_cnt     <= '0;
      parity      <= 8'h00;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= 8'h00;
      cmd_err_q   <= 1'b0;
    end else begin
      rd_idx      <= rd_idx_d;
      gap_cnt     <= gap_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      cmd_err_q   <= cmd_fire && !cmd_ok;
      if (cmd_fire && cmd_ok) begin
        dest_q   <= bus.cmd_dest;
        len_q    <= bus.cmd_len;
        fill_cnt <= 4'd0;
        // Seeding with the inverted header inverts the final parity.
        parity   <= {2'b00, bus.cmd_len, bus.cmd_dest} ^ {8{bus.err_inject}};
      end else if (pl_fire) begin
        fill_cnt <= fill_cnt + 4'd1;
        parity   <= parity ^ bus.pl_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pl_fire) mem[fill_cnt] <= bus.pl_data;
  end
endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: each packet is predicted as a byte list
// (header, payload, parity) and the wire is checked for timing and content.
module tb_router_pkt_tx;
  localparam int MAX_LEN    = 15;
  localparam int GAP_CYCLES = 2;

  typedef logic [7:0] bq_t[$];

  logic clk;
  logic resetn;
  int   cyc;
  int   n_checks;
  int   n_errors;

  router_pkt_tx_if bus ();

  router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid  = 1'b0;
    bus.pl_valid   = 1'b0;
    bus.busy       = 1'b0;
    bus.err_inject = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] d, input logic [3:0] l, input logic e, input bit ok);
    int k;
    k = 0;
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_dest   = d;
    bus.cmd_len    = l;
    bus.err_inject = e;
    bus.pl_valid   = 1'b0;
    bus.busy       = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("cmd_err", bus.cmd_err, !ok);
    check("tx_active_acc", bus.tx_active, ok);
    if (!ok) begin
      @(negedge clk);
      check("cmd_err_pulse", bus.cmd_err, 0);
      check("stay_idle", bus.cmd_ready, 1);
      check("no_pkt", bus.pkt_valid, 0);
    end
  endtask

  // hold<0: random busy while waiting; hold>=0: busy high for hold cycles once WAIT is entered.
  // rst_pos>=0: pulse reset while burst byte rst_pos is on the wire.
  task automatic run_pkt(input logic [1:0] dest, input logic [3:0] len, input logic err,
                         input bq_t pl, input bit stall, input int hold, input int rst_pos);
    bq_t        exp_q, got;
    logic [7:0] par;
    int         st, L, c, first, exp_hdr, gap, viol, v_zero, v_ready, v_act, v_contig;
    bit         b, ended, done;

    par = {2'b00, len, dest};
    exp_q.push_back(par);
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      par ^= pl[i];
    end
    if (err) par = ~par;
    exp_q.push_back(par);

    send_cmd(dest, len, err, 1'b1);

    viol = 0;
    foreach (pl[i]) begin
      st = stall ? $urandom_range(0, 2) : 0;
      repeat (st) begin
        bus.pl_valid  = 1'b0;
        bus.busy      = 1'($urandom_range(0, 1));
        if (bus.pkt_valid || bus.cmd_ready || bus.cmd_err) viol++;
        @(negedge clk);
      end
      bus.pl_valid  = 1'b1;
      bus.pl_data   = pl[i];
      bus.busy      = 1'($urandom_range(0, 1));
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_dest  = 2'($urandom);
      bus.cmd_len   = 4'($urandom);
      if (!bus.pl_ready || bus.pkt_valid || bus.cmd_ready || bus.cmd_err) viol++;
      @(negedge clk);
    end
    bus.pl_valid  = 1'b0;
    bus.cmd_valid = 1'b0;
    check("fill_phase", viol, 0);
    check("pl_ready_drop", bus.pl_ready, 0);
    L = cyc;

    first = -1; exp_hdr = -1; gap = 0;
    v_zero = 0; v_ready = 0; v_act = 0; v_contig = 0;
    ended = 1'b0; done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      c = cyc;
      if (bus.pkt_valid) begin
        if (ended) v_contig++;
        else begin
          if (first < 0) first = c;
          got.push_back(bus.pkt_data);
        end
      end else begin
        if (bus.pkt_data != 8'h00) v_zero++;
        if (first >= 0) ended = 1'b1;
        if (ended) begin
          if (bus.cmd_ready) done = 1'b1;
          else gap++;
        end
      end
      if (!done && bus.cmd_ready) v_ready++;
      if (bus.tx_active == bus.cmd_ready) v_act++;

      if (rst_pos >= 0 && bus.pkt_valid && !ended && got.size() == rst_pos + 1) begin
        check("rst_byte", got[rst_pos], exp_q[rst_pos]);
        #2 resetn = 1'b0;
        #1;
        check("rst_pkt_valid", bus.pkt_valid, 0);
        check("rst_pkt_data", bus.pkt_data, 0);
        check("rst_tx_active", bus.tx_active, 0);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_no_pkt", bus.pkt_valid, 0);
        return;
      end

      if (done) begin
        idle_inputs();
      end else begin
        if (exp_hdr < 0) begin
          if (hold >= 0) b = (hold > 0) && (c + 1 <= L + 1 + hold);
          else           b = 1'($urandom_range(0, 1));
          if (c + 1 >= L + 2 && !b) exp_hdr = c + 1;
        end else begin
          b = 1'($urandom_range(0, 1));
        end
        bus.busy      = b;
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_dest  = 2'($urandom);
        bus.cmd_len   = 4'($urandom);
        bus.pl_valid  = 1'($urandom_range(0, 1));
        bus.pl_data   = 8'($urandom);
        @(negedge clk);
      end
    end

    check("timeout", done, 1);
    check("hdr_cycle", first, exp_hdr);
    check("burst_len", got.size(), len + 2);
    foreach (exp_q[i])
      if (i < got.size()) check($sformatf("byte%0d", i), got[i], exp_q[i]);
    check("burst_contig", v_contig, 0);
    check("gap_cycles", gap, GAP_CYCLES);
    check("pkt_data_zero", v_zero, 0);
    check("cmd_ready_busy", v_ready, 0);
    check("tx_active", v_act, 0);
  endtask

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  initial begin
    bq_t        q;
    logic [1:0] d;
    logic [3:0] l;
    logic       e;
    bit         ok;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    resetn   = 1'b0;
    idle_inputs();
    bus.cmd_dest = 2'd0;
    bus.cmd_len  = 4'd0;
    bus.pl_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pkt_valid0", bus.pkt_valid, 0);
    check("rst_pkt_data0", bus.pkt_data, 0);
    check("rst_pl_ready0", bus.pl_ready, 0);
    check("rst_tx_active0", bus.tx_active, 0);
    check("rst_cmd_err0", bus.cmd_err, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", bus.cmd_ready, 1);

    q = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd0, 4'd3, 1'b0, q, 1'b0, 0, -1);
    q = '{8'hA5};
    run_pkt(2'd2, 4'd1, 1'b0, q, 1'b0, 0, -1);
    send_cmd(2'd1, 4'd0, 1'b0, 1'b0);
    send_cmd(2'd3, 4'd2, 1'b0, 1'b0);
    run_pkt(2'd0, 4'd4, 1'b0, rand_payload(4), 1'b0, 5, -1);
    run_pkt(2'd1, 4'd15, 1'b0, rand_payload(15), 1'b1, -1, -1);
    q = '{8'h11, 8'h22, 8'h33};
    run_pkt(2'd0, 4'd3, 1'b1, q, 1'b0, 0, -1);
    run_pkt(2'd0, 4'd3, 1'b0, q, 1'b0, 0, 2);
    run_pkt(2'd0, 4'd3, 1'b0, q, 1'b0, 0, -1);

    repeat (40) begin
      d  = 2'($urandom);
      l  = 4'($urandom);
      e  = 1'($urandom_range(0, 3) == 0);
      ok = (d != 2'd3) && (l != 4'd0) && (int'(l) <= MAX_LEN);
      if (!ok) send_cmd(d, l, e, 1'b0);
      else run_pkt(d, l, e, rand_payload(int'(l)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
